mem_port_arbiter: RTL and testbench

- Shares the single synchronous-read 16-bit memory port between three requesters:
  - instruction fetch unit (word reads),
  - CPU data path (byte loads/stores),
  - display reader (word reads).
- Grants at most one access per cycle. Routes read data back one cycle later.
- Starvation counters guarantee progress for fetch and data.
- Sits between the CPU/display blocks and the memory macro.

---
 rtl/cpu_common.sv | 13 +
 rtl/starve_counter.sv | 24 ++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_common.sv
// Shared CPU-side types and constants for the memory port and its clients.
package cpu_common;

  localparam int MEM_WORD_ADDR_WIDTH = 13;

  typedef enum logic [1:0] {
    MEM_REQ_NONE,
    MEM_REQ_FETCH,
    MEM_REQ_DATA,
    MEM_REQ_GFX
  } mem_requester_t;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive denied cycles of one requester, saturating at 7, and
// flags it as starved once the count reaches the supplied limit.
module starve_counter (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       req,
  input  logic       gnt,
  input  logic [2:0] limit,
  output logic       starved
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst_sync || !req || gnt) begin
      cnt <= 3'd0;
    end else if (cnt != 3'd7) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign starved = (cnt >= limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port 16-bit memory between fetch, data and display,
// one access per cycle, and steers read data back the following cycle.
module mem_port_arbiter
  import cpu_common::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           rst_sync,
  input  logic                           fetch_req,
  input  logic [MEM_WORD_ADDR_WIDTH-1:0] fetch_addr,
  output logic                           fetch_gnt,
  output logic                           fetch_rvalid,
  output logic [15:0]                    fetch_rdata,
  input  logic                           data_req,
  input  logic                           data_we,
  input  logic [13:0]                    data_addr,
  input  logic [7:0]                     data_wdata,
  output logic                           data_gnt,
  output logic                           data_rvalid,
  output logic [7:0]                     data_rdata,
  input  logic                           gfx_req,
  input  logic [MEM_WORD_ADDR_WIDTH-1:0] gfx_addr,
  output logic                           gfx_gnt,
  output logic                           gfx_rvalid,
  output logic [15:0]                    gfx_rdata,
  output logic                           mem_en,
  output logic [MEM_WORD_ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]                     mem_we,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  mem_requester_t sel;
  mem_requester_t read_sel;
  mem_requester_t last_grant;
  logic           last_byte_sel;
  logic           fetch_starved;
  logic           data_starved;
  logic           data_store;

  starve_counter u_fetch_starve (
    .clk      (clk),
    .rst_sync (rst_sync),
    .req      (fetch_req),
    .gnt      (fetch_gnt),
    .limit    (LIMIT),
    .starved  (fetch_starved)
  );

  starve_counter u_data_starve (
    .clk      (clk),
    .rst_sync (rst_sync),
    .req      (data_req),
    .gnt      (data_gnt),
    .limit    (LIMIT),
    .starved  (data_starved)
  );

  // Starved requesters jump ahead of display; otherwise gfx > data > fetch.
  always_comb begin
    sel = MEM_REQ_NONE;
    if (!rst_sync) begin
      if (data_req && data_starved)        sel = MEM_REQ_DATA;
      else if (fetch_req && fetch_starved) sel = MEM_REQ_FETCH;
      else if (gfx_req)                    sel = MEM_REQ_GFX;
      else if (data_req)                   sel = MEM_REQ_DATA;
      else if (fetch_req)                  sel = MEM_REQ_FETCH;
    end
  end

  assign fetch_gnt  = (sel == MEM_REQ_FETCH);
  assign data_gnt   = (sel == MEM_REQ_DATA);
  assign gfx_gnt    = (sel == MEM_REQ_GFX);
  assign data_store = data_gnt && data_we;

  always_comb begin
    mem_addr = '0;
    case (sel)
      MEM_REQ_FETCH: mem_addr = fetch_addr;
      MEM_REQ_DATA:  mem_addr = data_addr[13:1];
      MEM_REQ_GFX:   mem_addr = gfx_addr;
      default:       mem_addr = '0;
    endcase
  end

  assign mem_en    = (sel != MEM_REQ_NONE);
  assign mem_we    = data_store ? (data_addr[0] ? 2'b10 : 2'b01) : 2'b00;
  assign mem_wdata = {data_wdata, data_wdata};

  // Stores finish at the grant edge, so only reads are tracked for return.
  assign read_sel = data_store ? MEM_REQ_NONE : sel;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      last_grant <= MEM_REQ_NONE;
    end else begin
      last_grant <= read_sel;
    end
  end

  always_ff @(posedge clk) begin
    last_byte_sel <= data_addr[0];
  end

  assign fetch_rvalid = (last_grant == MEM_REQ_FETCH);
  assign data_rvalid  = (last_grant == MEM_REQ_DATA);
  assign gfx_rvalid   = (last_grant == MEM_REQ_GFX);
  assign fetch_rdata  = mem_rdata;
  assign gfx_rdata    = mem_rdata;
  assign data_rdata   = last_byte_sel ? mem_rdata[15:8] : mem_rdata[7:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_sync;
  logic        fetch_req;
  logic [12:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [15:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [13:0] data_addr;
  logic [7:0]  data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [7:0]  data_rdata;
  logic        gfx_req;
  logic [12:0] gfx_addr;
  logic        gfx_gnt;
  logic        gfx_rvalid;
  logic [15:0] gfx_rdata;
  logic        mem_en;
  logic [12:0] mem_addr;
  logic [1:0]  mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int passed;
  int total;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_sync     (rst_sync),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .gfx_req      (gfx_req),
    .gfx_addr     (gfx_addr),
    .gfx_gnt      (gfx_gnt),
    .gfx_rvalid   (gfx_rvalid),
    .gfx_rdata    (gfx_rdata),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {gfx_gnt, data_gnt, fetch_gnt} per cycle with all three requesting.
  logic [2:0] starve_seq [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};

  initial begin
    passed     = 0;
    total      = 0;
    rst_sync   = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    gfx_req    = 1'b0;
    gfx_addr   = '0;
    mem_rdata  = '0;
    step();
    step();

    // Reset state
    #1;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_rvalid", {29'd0, fetch_rvalid, data_rvalid, gfx_rvalid}, 32'd0);
    rst_sync = 1'b0;
    #1;
    check("idle_outputs", {28'd0, mem_en, fetch_gnt, data_gnt, gfx_gnt}, 32'd0);
    check("idle_mem_we", {30'd0, mem_we}, 32'd0);

    // Single fetch read
    fetch_req  = 1'b1;
    fetch_addr = 13'h0005;
    #1;
    check("fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
    check("fetch_mem_addr", {19'd0, mem_addr}, 32'h0005);
    check("fetch_mem_we", {30'd0, mem_we}, 32'd0);
    step();
    fetch_req = 1'b0;
    mem_rdata = 16'hBEEF;
    #1;
    check("fetch_rvalid", {29'd0, fetch_rvalid, data_rvalid, gfx_rvalid}, 32'b100);
    check("fetch_rdata", {16'd0, fetch_rdata}, 32'hBEEF);
    check("fetch_idle_after", {31'd0, mem_en}, 32'd0);

    // Byte store to odd address lands in the high byte lane
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 14'h0007;
    data_wdata = 8'h5A;
    #1;
    check("store_gnt", {31'd0, data_gnt}, 32'd1);
    check("store_mem_we", {30'd0, mem_we}, 32'b10);
    check("store_mem_addr", {19'd0, mem_addr}, 32'h0003);
    check("store_mem_wdata", {16'd0, mem_wdata}, 32'h5A5A);
    step();
    data_req = 1'b0;
    data_we  = 1'b0;
    #1;
    check("store_no_rvalid", {31'd0, data_rvalid}, 32'd0);

    // Back-to-back byte loads, even then odd
    data_req  = 1'b1;
    data_addr = 14'h0006;
    #1;
    check("load6_gnt", {31'd0, data_gnt}, 32'd1);
    check("load6_mem_we", {30'd0, mem_we}, 32'd0);
    step();
    data_addr = 14'h0007;
    mem_rdata = 16'h1234;
    #1;
    check("load6_rvalid", {31'd0, data_rvalid}, 32'd1);
    check("load6_rdata", {24'd0, data_rdata}, 32'h34);
    check("load7_gnt", {31'd0, data_gnt}, 32'd1);
    check("load7_mem_addr", {19'd0, mem_addr}, 32'h0003);
    step();
    data_req = 1'b0;
    #1;
    check("load7_rvalid", {31'd0, data_rvalid}, 32'd1);
    check("load7_rdata", {24'd0, data_rdata}, 32'h12);
    step();

    // Display read
    gfx_req  = 1'b1;
    gfx_addr = 13'h0100;
    #1;
    check("gfx_gnt", {31'd0, gfx_gnt}, 32'd1);
    check("gfx_mem_addr", {19'd0, mem_addr}, 32'h0100);
    step();
    gfx_req   = 1'b0;
    mem_rdata = 16'h55AA;
    #1;
    check("gfx_rvalid", {29'd0, fetch_rvalid, data_rvalid, gfx_rvalid}, 32'b001);
    check("gfx_rdata", {16'd0, gfx_rdata}, 32'h55AA);
    step();

    // Continuous gfx traffic: starvation promotes data, then fetch
    gfx_req   = 1'b1;
    data_req  = 1'b1;
    data_addr = 14'h0010;
    fetch_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("starve_c%0d", i), {29'd0, gfx_gnt, data_gnt, fetch_gnt}, {29'd0, starve_seq[i]});
      step();
    end
    gfx_req   = 1'b0;
    data_req  = 1'b0;
    fetch_req = 1'b0;
    step();
    step();

    // Fresh simultaneous requests, each dropped after its own grant
    gfx_req   = 1'b1;
    data_req  = 1'b1;
    fetch_req = 1'b1;
    #1;
    check("prio_c0", {29'd0, gfx_gnt, data_gnt, fetch_gnt}, 32'b100);
    step();
    gfx_req = 1'b0;
    #1;
    check("prio_c1", {29'd0, gfx_gnt, data_gnt, fetch_gnt}, 32'b010);
    step();
    data_req = 1'b0;
    #1;
    check("prio_c2", {29'd0, gfx_gnt, data_gnt, fetch_gnt}, 32'b001);
    step();
    fetch_req = 1'b0;
    step();

    // Reset in the same cycle as a fetch request
    fetch_req  = 1'b1;
    fetch_addr = 13'h0042;
    rst_sync   = 1'b1;
    #1;
    check("rst_fetch_gnt", {31'd0, fetch_gnt}, 32'd0);
    check("rst_fetch_mem_en", {31'd0, mem_en}, 32'd0);
    step();
    rst_sync  = 1'b0;
    fetch_req = 1'b0;
    #1;
    check("rst_no_rvalid", {29'd0, fetch_rvalid, data_rvalid, gfx_rvalid}, 32'd0);
    check("rst_fetch_cnt", {29'd0, dut.u_fetch_starve.cnt}, 32'd0);
    check("rst_data_cnt", {29'd0, dut.u_data_starve.cnt}, 32'd0);

    // Fresh fetch after reset release
    fetch_req  = 1'b1;
    fetch_addr = 13'h1ABC;
    #1;
    check("post_rst_gnt", {31'd0, fetch_gnt}, 32'd1);
    check("post_rst_addr", {19'd0, mem_addr}, 32'h1ABC);
    step();
    fetch_req = 1'b0;
    mem_rdata = 16'hCAFE;
    #1;
    check("post_rst_rvalid", {31'd0, fetch_rvalid}, 32'd1);
    check("post_rst_rdata", {16'd0, fetch_rdata}, 32'hCAFE);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
